// File: rtl/recorder_stream_serializer.sv
// Generic count-tracked FIFO: write port and combinational head read; pops are visible the same cycle.
// No internal flow control: the caller must never push when full without popping on the same edge.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic [CW-1:0]    count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic [CW-1:0]    count_q;

  // Storage is plain RAM; only the pointers and the count carry reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q[AW-1:0]] <= push_dat;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  assign pop_dat = mem[rd_ptr_q[AW-1:0]];
  assign count   = count_q;
endmodule

// Buffers wide recorder words and replays each as LSB-first OUT_WIDTH beats; 2 cycles in_valid->out_valid.
// out_ready stalls beats; the input cannot be stalled, so words arriving into a full FIFO are dropped and flagged.
module recorder_stream_serializer #(
  parameter int NUM_PORTS  = 1,
  parameter int DATA_WIDTH = 32,
  parameter int OUT_WIDTH  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int W          = NUM_PORTS * DATA_WIDTH,
  parameter int CW         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 clr,
  input  logic [W-1:0]         in_data,
  input  logic                 in_valid,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 overflow,
  output logic [CW-1:0]        fill_level
);
  localparam int BEATS = W / OUT_WIDTH;
  localparam int BW    = $clog2(BEATS);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  typedef enum logic {EMPTY, SEND} state_t;

  state_t         state_q, state_d;
  logic [BW-1:0]  beat_q, beat_d;
  logic [W-1:0]   word_q;
  logic           overflow_q, overflow_d;
  logic           pop, push, load;
  logic [W-1:0]   head_dat;
  logic [CW-1:0]  count;
  logic           fifo_has_word;
  logic           fifo_full;

  sync_fifo #(
    .WIDTH (W),
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk      (clk),
    .resetn   (resetn),
    .clr      (clr),
    .push     (push),
    .push_dat (in_data),
    .pop      (pop),
    .pop_dat  (head_dat),
    .count    (count)
  );

  assign fifo_has_word = (count != '0);
  assign fifo_full     = (count == CW'(FIFO_DEPTH));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= EMPTY;
      beat_q     <= '0;
      word_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      overflow_q <= overflow_d;
      if (load) word_q <= head_dat;
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    pop     = 1'b0;
    load    = 1'b0;
    if (clr) begin
      state_d = EMPTY;
      beat_d  = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (fifo_has_word) begin
            pop     = 1'b1;
            load    = 1'b1;
            beat_d  = '0;
            state_d = SEND;
          end
        end
        SEND: begin
          if (out_ready) begin
            if (beat_q == LAST_BEAT) begin
              beat_d = '0;
              // Chain straight into the next word so back-to-back words carry no bubble.
              if (fifo_has_word) begin
                pop  = 1'b1;
                load = 1'b1;
              end else begin
                state_d = EMPTY;
              end
            end else begin
              beat_d = beat_q + BW'(1);
            end
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // A full FIFO still accepts a word when its head leaves on the same edge.
  assign push       = in_valid && !clr && (!fifo_full || pop);
  assign overflow_d = clr ? 1'b0 : (overflow_q || (in_valid && !push));

  assign out_valid  = (state_q == SEND);
  assign out_last   = out_valid && (beat_q == LAST_BEAT);
  assign out_data   = out_valid ? word_q[int'(beat_q)*OUT_WIDTH +: OUT_WIDTH] : '0;
  assign overflow   = overflow_q;
  assign fill_level = count;
endmodule

// File: tb/tb_recorder_stream_serializer.sv
// Directed and randomized checks of the serializer against a queue-based reference model.
module tb_recorder_stream_serializer;
  localparam int BEATS = 4;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        clr = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_last;
  logic        overflow;
  logic [2:0]  fill_level;

  always #5 clk = ~clk;

  recorder_stream_serializer #(
    .NUM_PORTS  (1),
    .DATA_WIDTH (32),
    .OUT_WIDTH  (8),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .clr        (clr),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .overflow   (overflow),
    .fill_level (fill_level)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference: queue of stored words plus the word currently being replayed.
  logic [31:0] mq[$];
  logic        m_busy;
  logic        m_ovf;
  logic [31:0] m_cur;
  int          m_beat;

  logic [8:0]  got[$];
  int          got_cyc[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_busy = 1'b0;
    m_ovf  = 1'b0;
    m_cur  = '0;
    m_beat = 0;
  endtask

  task automatic model_edge();
    int  n_pre;
    bit  popped;
    n_pre  = mq.size();
    popped = 0;
    if (clr) begin
      model_reset();
    end else begin
      if (!m_busy) begin
        if (n_pre > 0) begin
          m_cur = mq.pop_front(); m_beat = 0; m_busy = 1'b1; popped = 1;
        end
      end else if (out_ready) begin
        if (m_beat == BEATS - 1) begin
          m_beat = 0;
          if (n_pre > 0) begin
            m_cur = mq.pop_front(); popped = 1;
          end else begin
            m_busy = 1'b0;
          end
        end else begin
          m_beat++;
        end
      end
      if (in_valid) begin
        if (n_pre < DEPTH || popped) mq.push_back(in_data);
        else m_ovf = 1'b1;
      end
    end
  endtask

  task automatic check_outs(input string tag);
    chk({tag, ".valid"}, 32'(out_valid), 32'(m_busy));
    chk({tag, ".last"}, 32'(out_last), 32'(m_busy && m_beat == BEATS - 1));
    chk({tag, ".fill"}, 32'(fill_level), 32'(mq.size()));
    chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
    if (m_busy) chk({tag, ".data"}, 32'(out_data), 32'(m_cur[m_beat*8 +: 8]));
  endtask

  task automatic cycle(input string tag, input logic v, input logic [31:0] d,
                       input logic r, input logic c);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    clr       = c;
    #1;
    if (out_valid && out_ready && !clr) begin
      got.push_back({out_last, out_data});
      got_cyc.push_back(cyc);
    end
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    check_outs(tag);
  endtask

  function automatic logic [8:0] beat_of(input logic [31:0] w, input int b);
    return {b == BEATS - 1, w[b*8 +: 8]};
  endfunction

  initial begin
    model_reset();
    // Reset state
    #1 resetn = 1'b0;
    #1;
    chk("rst.valid", 32'(out_valid), 32'd0);
    chk("rst.data", 32'(out_data), 32'd0);
    chk("rst.last", 32'(out_last), 32'd0);
    chk("rst.ovf", 32'(overflow), 32'd0);
    chk("rst.fill", 32'(fill_level), 32'd0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;

    // Single word, 2-cycle latency, LSB-first beats
    cycle("t1", 1, 32'h04030201, 1, 0);
    chk("t1.lat1", 32'(out_valid), 32'd0);
    cycle("t1", 0, 0, 1, 0);
    chk("t1.lat2", 32'(out_valid), 32'd1);
    chk("t1.b0", 32'(out_data), 32'h01);
    cycle("t1", 0, 0, 1, 0);
    chk("t1.b1", 32'(out_data), 32'h02);
    cycle("t1", 0, 0, 1, 0);
    chk("t1.b2", 32'(out_data), 32'h03);
    cycle("t1", 0, 0, 1, 0);
    chk("t1.b3", 32'(out_data), 32'h04);
    chk("t1.b3last", 32'(out_last), 32'd1);
    cycle("t1", 0, 0, 1, 0);
    chk("t1.done", 32'(out_valid), 32'd0);
    chk("t1.fill", 32'(fill_level), 32'd0);
    chk("t1.ovf", 32'(overflow), 32'd0);

    // Back-to-back words without a bubble
    got.delete(); got_cyc.delete();
    cycle("t2", 1, 32'h11111111, 1, 0);
    repeat (3) cycle("t2", 0, 0, 1, 0);
    cycle("t2", 1, 32'h22222222, 1, 0);
    repeat (10) cycle("t2", 0, 0, 1, 0);
    chk("t2.n", 32'(got.size()), 32'd8);
    if (got.size() == 8) begin
      for (int i = 0; i < 8; i++)
        chk("t2.beat", 32'(got[i]), 32'(beat_of(i < 4 ? 32'h11111111 : 32'h22222222, i % 4)));
      chk("t2.span", 32'(got_cyc[7] - got_cyc[0]), 32'd7);
    end

    // Overflow with stalled sink, then full-plus-pop accept, then drain
    for (int k = 1; k <= 6; k++) cycle("t3", 1, 32'(k), 0, 0);
    chk("t3.fill", 32'(fill_level), 32'd4);
    chk("t3.ovf", 32'(overflow), 32'd1);
    chk("t3.head", 32'(out_data), 32'h01);
    got.delete(); got_cyc.delete();
    repeat (3) cycle("t3", 0, 0, 1, 0);
    cycle("t3", 1, 32'd7, 1, 0);
    chk("t3.fullpop.fill", 32'(fill_level), 32'd4);
    chk("t3.fullpop.ovf", 32'(overflow), 32'd1);
    repeat (26) cycle("t3", 0, 0, 1, 0);
    chk("t3.n", 32'(got.size()), 32'd24);
    if (got.size() == 24) begin
      for (int i = 0; i < 24; i++)
        chk("t3.beat", 32'(got[i]), 32'(beat_of(i < 20 ? 32'(i / 4 + 1) : 32'd7, i % 4)));
    end

    // Back-pressure: beats held while ready is low
    got.delete(); got_cyc.delete();
    cycle("t4", 1, 32'hA4A3A2A1, 0, 0);
    cycle("t4", 0, 0, 0, 0);
    begin
      logic [6:0] pat;
      pat = 7'b1001101;
      for (int i = 6; i >= 0; i--) cycle("t4", 0, 0, pat[i], 0);
    end
    chk("t4.n", 32'(got.size()), 32'd4);
    if (got.size() == 4)
      for (int i = 0; i < 4; i++) chk("t4.beat", 32'(got[i]), 32'(beat_of(32'hA4A3A2A1, i)));
    chk("t4.done", 32'(out_valid), 32'd0);

    // clr mid-word with overflow set and three words buffered
    for (int k = 0; k < 4; k++) cycle("t5", 1, 32'h50 + 32'(k), 0, 0);
    cycle("t5", 0, 0, 1, 0);
    cycle("t5", 0, 0, 1, 0);
    chk("t5.pre.fill", 32'(fill_level), 32'd3);
    chk("t5.pre.ovf", 32'(overflow), 32'd1);
    cycle("t5", 1, 32'hDEADBEEF, 0, 1);
    chk("t5.valid", 32'(out_valid), 32'd0);
    chk("t5.fill", 32'(fill_level), 32'd0);
    chk("t5.ovf", 32'(overflow), 32'd0);
    got.delete(); got_cyc.delete();
    cycle("t5", 1, 32'h0D0C0B0A, 1, 0);
    repeat (7) cycle("t5", 0, 0, 1, 0);
    chk("t5.n", 32'(got.size()), 32'd4);
    if (got.size() == 4)
      for (int i = 0; i < 4; i++) chk("t5.beat", 32'(got[i]), 32'(beat_of(32'h0D0C0B0A, i)));

    // Async reset mid-word
    for (int k = 0; k < 3; k++) cycle("t6", 1, 32'h60 + 32'(k), 0, 0);
    cycle("t6", 0, 0, 1, 0);
    chk("t6.pre.fill", 32'(fill_level), 32'd2);
    in_valid = 1'b0; out_ready = 1'b0;
    #2 resetn = 1'b0;
    #1;
    chk("t6.valid", 32'(out_valid), 32'd0);
    chk("t6.data", 32'(out_data), 32'd0);
    chk("t6.last", 32'(out_last), 32'd0);
    chk("t6.fill", 32'(fill_level), 32'd0);
    chk("t6.ovf", 32'(overflow), 32'd0);
    model_reset();
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    repeat (5) cycle("t6.post", 0, 0, 1, 0);
    chk("t6.post.valid", 32'(out_valid), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++)
      cycle("rnd", 1'($urandom_range(0, 2) == 0), $urandom(),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 60) == 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
